ascon_aead: RTL and testbench

- Ascon-128 AEAD engine, 64-bit rate, streaming one 64-bit word per handshake.
- Per message, the block loads key and nonce, runs initialization, and encrypts or decrypts caller-padded 64-bit blocks.
- It then emits the 128-bit tag as two words.
- Iterative datapath: one permutation round per clock. Sits between a DMA/stream front end and the tag-check logic.

---
 rtl/ascon_pkg.sv | 26 ++
 rtl/ascon_round.sv | 50 +++++
 rtl/ascon_aead.sv | 150 +++++++++++++++
 tb/tb_ascon_aead.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// ascon_pkg: shared constants, round-constant table and FSM states for the Ascon-128 AEAD engine
package ascon_pkg;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    // Ascon-128 IV: k=128, r=64, a=12, b=6
    localparam logic [63:0] IV = 64'h80400C0600000000;

    // Round constants for rounds 0..11 (entry [0] = 0xF0); data rounds use entries 6..11
    localparam logic [11:0][7:0] RC = {
        8'h4B, 8'h5A, 8'h69, 8'h78, 8'h87, 8'h96,
        8'hA5, 8'hB4, 8'hC3, 8'hD2, 8'hE1, 8'hF0
    };

    typedef enum logic [3:0] {
        LOAD_K0, LOAD_K1, LOAD_N0, LOAD_N1,
        INIT_PERM, DATA, DATA_PERM, FINAL_PERM,
        TAG0, TAG1
    } state_t;

    function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
        return (v >> n) | (v << (64 - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational Ascon permutation round
// Ports:
//   x0..x4  in   64  state words before the round
//   rc      in   8   round constant, added to x2
//   y0..y4  out  64  state words after constant, S-box and linear layers
module ascon_round
    import ascon_pkg::*;
(
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    input  logic [7:0]  rc,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4
);

    logic [63:0] a0, a1, a2, a3, a4;
    logic [63:0] t0, t1, t2, t3, t4;
    logic [63:0] s0, s1, s2, s3, s4;

    // Bitsliced 5-bit S-box: input mixing, chi step, output mixing
    always_comb begin
        a0 = x0 ^ x4;
        a1 = x1;
        a2 = x2 ^ {56'd0, rc} ^ x1;
        a3 = x3;
        a4 = x4 ^ x3;
        t0 = a0 ^ (~a1 & a2);
        t1 = a1 ^ (~a2 & a3);
        t2 = a2 ^ (~a3 & a4);
        t3 = a3 ^ (~a4 & a0);
        t4 = a4 ^ (~a0 & a1);
        s0 = t0 ^ t4;
        s1 = t1 ^ t0;
        s2 = ~t2;
        s3 = t3 ^ t2;
        s4 = t4;
        y0 = s0 ^ ror(s0, 19) ^ ror(s0, 28);
        y1 = s1 ^ ror(s1, 61) ^ ror(s1, 39);
        y2 = s2 ^ ror(s2, 1)  ^ ror(s2, 6);
        y3 = s3 ^ ror(s3, 10) ^ ror(s3, 17);
        y4 = s4 ^ ror(s4, 7)  ^ ror(s4, 41);
    end

endmodule

// File: rtl/ascon_aead.sv
// ascon_aead: iterative Ascon-128 AEAD engine, one 64-bit word per handshake, tag out as two words
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   mode              0 = encrypt, 1 = decrypt; latched with the first key word
//   block_in[63:0]    key, nonce, then caller-padded data words
//   block_in_valid    block_in is valid
//   block_in_last     final data block marker
//   block_in_ready    engine accepts block_in this cycle
//   block_out[63:0]   cipher/plain word or tag word; holds when not valid
//   block_out_valid   one-cycle output strobe
//   block_out_last    high with the second tag word
// Build option: define ASCON_UNROLL2_EN to evaluate two rounds per clock.
module ascon_aead
    import ascon_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        mode,
    input  logic [63:0] block_in,
    input  logic        block_in_valid,
    input  logic        block_in_last,
    output logic        block_in_ready,
    output logic [63:0] block_out,
    output logic        block_out_valid,
    output logic        block_out_last
);

`ifdef ASCON_UNROLL2_EN
    localparam logic [3:0] STEP = 4'd2;
`else
    localparam logic [3:0] STEP = 4'd1;
`endif
    localparam logic [3:0] LAST_RND   = 4'd12 - STEP;
    localparam logic [3:0] DATA_START = 4'd6;

    state_t      state, state_nx;
    logic [63:0] x0, x1, x2, x3, x4;
    logic [63:0] p0, p1, p2, p3, p4;
    logic [63:0] k_hi, k_lo;
    logic [3:0]  rnd;
    logic        mode_r;
    logic        armed;
    logic        accept;
    logic        perm;
    logic        perm_done;

    // armed keeps ready low through the reset cycle until the first clock after release
    assign block_in_ready = armed && (state inside {LOAD_K0, LOAD_K1, LOAD_N0, LOAD_N1, DATA});
    assign accept         = block_in_valid && block_in_ready;
    assign perm           = state inside {INIT_PERM, DATA_PERM, FINAL_PERM};
    assign perm_done      = rnd == LAST_RND;

`ifdef ASCON_UNROLL2_EN
    logic [63:0] m0, m1, m2, m3, m4;
    ascon_round u_round0 (
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .rc(RC[rnd]),
        .y0(m0), .y1(m1), .y2(m2), .y3(m3), .y4(m4)
    );
    ascon_round u_round1 (
        .x0(m0), .x1(m1), .x2(m2), .x3(m3), .x4(m4), .rc(RC[rnd + 4'd1]),
        .y0(p0), .y1(p1), .y2(p2), .y3(p3), .y4(p4)
    );
`else
    ascon_round u_round0 (
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .rc(RC[rnd]),
        .y0(p0), .y1(p1), .y2(p2), .y3(p3), .y4(p4)
    );
`endif

    always_comb begin
        state_nx = state;
        case (state)
            LOAD_K0:    state_nx = accept ? LOAD_K1 : state;
            LOAD_K1:    state_nx = accept ? LOAD_N0 : state;
            LOAD_N0:    state_nx = accept ? LOAD_N1 : state;
            LOAD_N1:    state_nx = accept ? INIT_PERM : state;
            INIT_PERM:  state_nx = perm_done ? DATA : state;
            DATA:       state_nx = accept ? (block_in_last ? FINAL_PERM : DATA_PERM) : state;
            DATA_PERM:  state_nx = perm_done ? DATA : state;
            FINAL_PERM: state_nx = perm_done ? TAG0 : state;
            TAG0:       state_nx = TAG1;
            TAG1:       state_nx = LOAD_K0;
            default:    state_nx = LOAD_K0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= LOAD_K0;
            armed           <= 1'b0;
            rnd             <= 4'd0;
            mode_r          <= MODE_ENC;
            {x0, x1, x2, x3, x4} <= '0;
            k_hi            <= '0;
            k_lo            <= '0;
            block_out       <= '0;
            block_out_valid <= 1'b0;
            block_out_last  <= 1'b0;
        end else begin
            state           <= state_nx;
            armed           <= 1'b1;
            // Data permutations start mid-schedule at round 6; all others start at 0
            rnd             <= (perm && !perm_done) ? rnd + STEP :
                               (state == DATA && !block_in_last) ? DATA_START : 4'd0;
            block_out_valid <= 1'b0;
            block_out_last  <= 1'b0;
            case (state)
                LOAD_K0: if (accept) begin
                    k_hi   <= block_in;
                    mode_r <= mode;
                end
                LOAD_K1: if (accept) k_lo <= block_in;
                LOAD_N0: if (accept) x3 <= block_in;
                LOAD_N1: if (accept) begin
                    x0 <= IV;
                    x1 <= k_hi;
                    x2 <= k_lo;
                    x4 <= block_in;
                end
                INIT_PERM: begin
                    {x0, x1, x2} <= {p0, p1, p2};
                    x3 <= perm_done ? p3 ^ k_hi : p3;
                    x4 <= perm_done ? p4 ^ k_lo ^ 64'd1 : p4;
                end
                DATA: if (accept) begin
                    block_out       <= x0 ^ block_in;
                    block_out_valid <= 1'b1;
                    x0 <= (mode_r == MODE_DEC) ? block_in : x0 ^ block_in;
                    x1 <= block_in_last ? x1 ^ k_hi : x1;
                    x2 <= block_in_last ? x2 ^ k_lo : x2;
                end
                DATA_PERM: {x0, x1, x2, x3, x4} <= {p0, p1, p2, p3, p4};
                FINAL_PERM: begin
                    {x0, x1, x2, x3, x4} <= {p0, p1, p2, p3, p4};
                    if (perm_done) begin
                        block_out       <= p3 ^ k_hi;
                        block_out_valid <= 1'b1;
                    end
                end
                TAG0: begin
                    block_out       <= x4 ^ k_lo;
                    block_out_valid <= 1'b1;
                    block_out_last  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ascon_aead.sv
// tb_ascon_aead: randomized self-checking bench for ascon_aead against a table-driven Ascon model
module tb_ascon_aead;

`ifdef ASCON_UNROLL2_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int INIT_CYC = 12 / STEP;
    localparam int DP_CYC   = 6 / STEP;

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int R1 [5] = '{19, 61, 1, 10, 7};
    localparam int R2 [5] = '{28, 39, 6, 17, 41};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mode = 1'b0;
    logic [63:0] block_in = '0;
    logic        block_in_valid = 1'b0;
    logic        block_in_last = 1'b0;
    logic        block_in_ready;
    logic [63:0] block_out;
    logic        block_out_valid;
    logic        block_out_last;

    int checks = 0;
    int errors = 0;

    logic [63:0]  ms [5];
    logic [63:0]  exp_q [$];
    logic [64:0]  outq [$];
    logic [63:0]  saved [$];
    logic [63:0]  pt [8];
    logic [127:0] key, non;
    logic [63:0]  blk [8];
    int           nb;

    ascon_aead dut (
        .clk(clk),
        .rst(rst),
        .mode(mode),
        .block_in(block_in),
        .block_in_valid(block_in_valid),
        .block_in_last(block_in_last),
        .block_in_ready(block_in_ready),
        .block_out(block_out),
        .block_out_valid(block_out_valid),
        .block_out_last(block_out_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (block_out_valid) outq.push_back({block_out_last, block_out});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic model_perm(input int first);
        logic [63:0] t [5];
        logic [4:0]  v;
        for (int r = first; r < 12; r++) begin
            ms[2] ^= 64'((15 - r) * 16 + r);
            for (int b = 0; b < 64; b++) begin
                v = SBOX[{ms[0][b], ms[1][b], ms[2][b], ms[3][b], ms[4][b]}];
                for (int j = 0; j < 5; j++) t[j][b] = v[4 - j];
            end
            for (int j = 0; j < 5; j++) ms[j] = t[j] ^ rotr(t[j], R1[j]) ^ rotr(t[j], R2[j]);
        end
    endtask

    task automatic model_msg(input bit dec);
        logic [63:0] o;
        exp_q.delete();
        ms[0] = 64'h80400C0600000000;
        ms[1] = key[127:64];
        ms[2] = key[63:0];
        ms[3] = non[127:64];
        ms[4] = non[63:0];
        model_perm(0);
        ms[3] ^= key[127:64];
        ms[4] ^= key[63:0] ^ 64'd1;
        for (int i = 0; i < nb; i++) begin
            o = ms[0] ^ blk[i];
            exp_q.push_back(o);
            ms[0] = dec ? blk[i] : o;
            if (i < nb - 1) model_perm(6);
            else begin
                ms[1] ^= key[127:64];
                ms[2] ^= key[63:0];
                model_perm(0);
            end
        end
        exp_q.push_back(ms[3] ^ key[127:64]);
        exp_q.push_back(ms[4] ^ key[63:0]);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge
    task automatic send(input logic [63:0] w, input bit lst);
        int n = 0;
        block_in = w;
        block_in_last = lst;
        block_in_valid = 1'b1;
        while (!block_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_at_send", 64'(block_in_ready), 64'd1);
        @(negedge clk);
        block_in_valid = 1'b0;
    endtask

    task automatic busy(output int n);
        n = 0;
        while (!block_in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_msg(input bit dec, input bit flip, input int stall);
        int n = 0;
        model_msg(dec);
        outq.delete();
        mode = dec;
        send(key[127:64], 1'b0);
        if (flip) mode = ~dec;
        send(key[63:0], 1'b0);
        send(non[127:64], 1'b0);
        send(non[63:0], 1'b0);
        for (int i = 0; i < nb; i++) begin
            send(blk[i], i == nb - 1);
            if (i == 0 && stall > 0) begin
                repeat (stall) @(negedge clk);
                check("stall_quiet", 64'(outq.size()), 64'd1);
            end
        end
        while (outq.size() < nb + 2 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("out_count", 64'(outq.size()), 64'(nb + 2));
        for (int i = 0; i < nb + 2 && i < outq.size(); i++) begin
            check("out_word", outq[i][63:0], exp_q[i]);
            check("out_last", 64'(outq[i][64]), 64'(i == nb + 1));
        end
    endtask

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 64'(block_in_ready), 64'd0);
        check("rst_out", block_out, 64'd0);
        check("rst_valid", 64'(block_out_valid), 64'd0);
        check("rst_last", 64'(block_out_last), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(block_in_ready), 64'd1);

        // Known-answer test: empty message padded to one block
        key = 128'h000102030405060708090A0B0C0D0E0F;
        non = key;
        blk[0] = 64'h8000000000000000;
        nb = 1;
        run_msg(1'b0, 1'b0, 0);
        if (outq.size() == 3) begin
            check("kat_tag0", outq[1][63:0], 64'hE355159F292911F7);
            check("kat_tag1", outq[2][63:0], 64'h94CB1432A0103A8A);
        end

        // Cycle timing
        key = {64'hD000000DC000000C, 64'hB000000BA000000A};
        non = {64'h4000000430000003, 64'h2000000210000001};
        blk[0] = 64'hFFFF000000000000;
        blk[1] = 64'h1000000000000000;
        nb = 2;
        model_msg(1'b0);
        mode = 1'b0;
        send(key[127:64], 1'b0);
        send(key[63:0], 1'b0);
        send(non[127:64], 1'b0);
        send(non[63:0], 1'b0);
        busy(n);
        check("init_busy", 64'(n), 64'(INIT_CYC));
        send(blk[0], 1'b0);
        check("d0_valid", 64'(block_out_valid), 64'd1);
        check("d0_word", block_out, exp_q[0]);
        busy(n);
        check("dperm_busy", 64'(n), 64'(DP_CYC));
        send(blk[1], 1'b1);
        check("d1_valid", 64'(block_out_valid), 64'd1);
        check("d1_word", block_out, exp_q[1]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!block_out_valid && n < 50);
        check("final_gap", 64'(n), 64'(INIT_CYC));
        check("tag0_word", block_out, exp_q[2]);
        check("tag0_last", 64'(block_out_last), 64'd0);
        @(negedge clk);
        check("tag1_valid", 64'(block_out_valid), 64'd1);
        check("tag1_word", block_out, exp_q[3]);
        check("tag1_last", 64'(block_out_last), 64'd1);
        @(negedge clk);
        check("post_tag_valid", 64'(block_out_valid), 64'd0);
        check("post_tag_ready", 64'(block_in_ready), 64'd1);

        // Asynchronous reset in the middle of a data permutation
        key = {rand64(), rand64()};
        non = {rand64(), rand64()};
        mode = 1'b0;
        send(key[127:64], 1'b0);
        send(key[63:0], 1'b0);
        send(non[127:64], 1'b0);
        send(non[63:0], 1'b0);
        send(rand64(), 1'b0);
        #2 rst = 1'b1;
        #1;
        check("arst_out", block_out, 64'd0);
        check("arst_valid", 64'(block_out_valid), 64'd0);
        check("arst_last", 64'(block_out_last), 64'd0);
        check("arst_ready", 64'(block_in_ready), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("arst_ready_after", 64'(block_in_ready), 64'd1);
        key = {rand64(), rand64()};
        non = {rand64(), rand64()};
        for (int i = 0; i < 2; i++) blk[i] = rand64();
        nb = 2;
        run_msg(1'b0, 1'b0, 0);

        // Back-to-back vs stalled encryption, then round-trip decryption
        key = {rand64(), rand64()};
        non = {rand64(), rand64()};
        nb = 3;
        for (int i = 0; i < nb; i++) begin
            blk[i] = rand64();
            pt[i] = blk[i];
        end
        run_msg(1'b0, 1'b0, 0);
        saved.delete();
        foreach (outq[i]) saved.push_back(outq[i][63:0]);
        run_msg(1'b0, 1'b0, 20);
        for (int i = 0; i < outq.size() && i < saved.size(); i++) check("stall_same", outq[i][63:0], saved[i]);
        for (int i = 0; i < nb && i < saved.size(); i++) blk[i] = saved[i];
        run_msg(1'b1, 1'b0, 0);
        for (int i = 0; i < nb && i < outq.size(); i++) check("rt_plain", outq[i][63:0], pt[i]);
        for (int i = nb; i < nb + 2 && i < outq.size() && i < saved.size(); i++) check("rt_tag", outq[i][63:0], saved[i]);

        // Mode toggled after the first key word must not affect the message
        key = {rand64(), rand64()};
        non = {rand64(), rand64()};
        nb = 2;
        for (int i = 0; i < nb; i++) blk[i] = rand64();
        run_msg(1'b0, 1'b1, 0);
        run_msg(1'b1, 1'b1, 0);

        // Random messages
        for (int m = 0; m < 5; m++) begin
            key = {rand64(), rand64()};
            non = {rand64(), rand64()};
            nb = 1 + int'($urandom_range(0, 3));
            for (int i = 0; i < nb; i++) blk[i] = rand64();
            run_msg(1'($urandom_range(0, 1)), 1'b0, (m == 2 && nb > 1) ? 9 : 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
